// File: rtl/servo_ramp_sequencer.sv
// Host-programmable slew limiter: once per frame tick it walks every servo's current
// position toward its target and streams the packed position words into the PWM block.
module servo_ramp_sequencer #(
    parameter int NUM_SERVO = 2,
    parameter int FRAME_DIV = 1000000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [4:0]  HAddr,
    input  logic [15:0] HDataWr,
    output logic [15:0] HDataRd,
    input  logic        HWr,
    input  logic        HEn,
    output logic [4:0]  SAddr,
    output logic [15:0] SDataWr,
    output logic        SWr,
    output logic        SEn,
    output logic        Busy
);
    localparam int NUM_WORD = NUM_SERVO / 2;
    localparam int KW = (NUM_WORD > 1) ? $clog2(NUM_WORD) : 1;
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [4:0] ADDR_CUR  = 5'h10;
    localparam logic [4:0] ADDR_STEP = 5'h1E;
    localparam logic [4:0] ADDR_CTRL = 5'h1F;

    typedef enum logic [1:0] {IDLE, CALC, WRITE, ENWR} state_t;
    typedef enum logic {RAMP, REFRESH} mode_t;

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [KW-1:0] k_q, k_d;
    logic          en_data_q, en_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tgt_q [NUM_SERVO];
    logic [7:0]    tgt_d [NUM_SERVO];
    logic [7:0]    cur_q [NUM_SERVO];
    logic [7:0]    cur_d [NUM_SERVO];
    logic [7:0]    step_q, step_d;
    logic          enable_q, enable_d;
    logic          overrun_q, overrun_d;
    logic          pend_rise_q, pend_rise_d;
    logic          pend_fall_q, pend_fall_d;
    logic          host_wr;
    logic          tick;

    assign host_wr = HWr & HEn;
    assign tick    = (cnt_q == CW'(FRAME_DIV - 1));

    // One slew step in 9-bit arithmetic; the result lands on tgt rather than crossing it.
    function automatic logic [7:0] ramp_pos(input logic [7:0] cur, input logic [7:0] tgt,
                                            input logic [7:0] step);
        logic [8:0] sum;
        logic [8:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (step == 8'd0)
            return tgt;
        else if (cur < tgt)
            return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
        else if (cur > tgt)
            return (diff[8] || (diff[7:0] < tgt)) ? tgt : diff[7:0];
        else
            return cur;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        mode_d      = mode_q;
        k_d         = k_q;
        en_data_d   = en_data_q;
        cur_d       = cur_q;
        tgt_d       = tgt_q;
        step_d      = step_q;
        enable_d    = enable_q;
        overrun_d   = overrun_q;
        pend_rise_d = pend_rise_q;
        pend_fall_d = pend_fall_q;
        cnt_d       = tick ? '0 : cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (pend_fall_q) begin
                    state_d     = ENWR;
                    en_data_d   = 1'b0;
                    pend_fall_d = 1'b0;
                end else if (pend_rise_q) begin
                    state_d     = CALC;
                    mode_d      = REFRESH;
                    k_d         = '0;
                    pend_rise_d = 1'b0;
                end else if (tick && enable_q) begin
                    state_d = CALC;
                    mode_d  = RAMP;
                    k_d     = '0;
                end
            end
            CALC: begin
                if (mode_q == RAMP) begin
                    for (int i = 0; i < NUM_SERVO; i++) begin
                        if (KW'(i / 2) == k_q) cur_d[i] = ramp_pos(cur_q[i], tgt_q[i], step_q);
                    end
                end
                state_d = WRITE;
            end
            WRITE: begin
                if (k_q == KW'(NUM_WORD - 1)) begin
                    if (mode_q == RAMP) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = ENWR;
                        en_data_d = 1'b1;
                    end
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = CALC;
                end
            end
            ENWR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (host_wr) begin
            for (int w = 0; w < NUM_WORD; w++) begin
                if (HAddr == 5'(w)) begin
                    tgt_d[2*w]   = HDataWr[7:0];
                    tgt_d[2*w+1] = HDataWr[15:8];
                end
            end
            if (HAddr == ADDR_STEP) step_d = HDataWr[7:0];
            if (HAddr == ADDR_CTRL) begin
                enable_d = HDataWr[0];
                // The host's latest edge supersedes any edge still waiting for IDLE.
                if (HDataWr[0] && !enable_q) begin
                    pend_rise_d = 1'b1;
                    pend_fall_d = 1'b0;
                end else if (!HDataWr[0] && enable_q) begin
                    pend_fall_d = 1'b1;
                    pend_rise_d = 1'b0;
                end
                if (HDataWr[2]) overrun_d = 1'b0;
            end
        end

        if (tick && enable_q && (state_q != IDLE || pend_rise_q || pend_fall_q))
            overrun_d = 1'b1;
    end

    always_comb begin
        SAddr   = '0;
        SDataWr = '0;
        SWr     = 1'b0;
        case (state_q)
            WRITE: begin
                SWr   = 1'b1;
                SAddr = 5'(k_q);
                for (int w = 0; w < NUM_WORD; w++) begin
                    if (k_q == KW'(w)) SDataWr = {cur_q[2*w+1], cur_q[2*w]};
                end
            end
            ENWR: begin
                SWr     = 1'b1;
                SAddr   = ADDR_CTRL;
                SDataWr = {15'b0, en_data_q};
            end
            default: ;
        endcase
    end

    assign SEn  = SWr;
    assign Busy = (state_q != IDLE);

    always_comb begin
        HDataRd = '0;
        for (int w = 0; w < NUM_WORD; w++) begin
            if (HAddr == 5'(w))            HDataRd = {tgt_q[2*w+1], tgt_q[2*w]};
            if (HAddr == ADDR_CUR + 5'(w)) HDataRd = {cur_q[2*w+1], cur_q[2*w]};
        end
        if (HAddr == ADDR_STEP) HDataRd = {8'b0, step_q};
        if (HAddr == ADDR_CTRL) HDataRd = {13'b0, overrun_q, Busy, enable_q};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            mode_q      <= RAMP;
            k_q         <= '0;
            en_data_q   <= 1'b0;
            cnt_q       <= '0;
            step_q      <= 8'd0;
            enable_q    <= 1'b0;
            overrun_q   <= 1'b0;
            pend_rise_q <= 1'b0;
            pend_fall_q <= 1'b0;
            // NOTE: the position arrays are flops, not RAM, so they can reset to mid-scale and servos never start from garbage.
            for (int i = 0; i < NUM_SERVO; i++) begin
                tgt_q[i] <= 8'h80;
                cur_q[i] <= 8'h80;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            en_data_q   <= en_data_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            enable_q    <= enable_d;
            overrun_q   <= overrun_d;
            pend_rise_q <= pend_rise_d;
            pend_fall_q <= pend_fall_d;
            tgt_q       <= tgt_d;
            cur_q       <= cur_d;
        end
    end

endmodule
